// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared types and constants for the data-memory arbiter
package dm_arbiter_pkg;
  localparam int DATA_W = 16;
  typedef enum logic [0:0] {PRIO_CPU, PRIO_HOST} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_e;
endpackage

// File: rtl/dm_starve_counter.sv
// dm_starve_counter: saturating host wait counter, hit flags the value being entered this cycle
module dm_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);
  logic [W-1:0] count_q, count_d;
  always_comb begin
    count_d = clr ? '0 : (inc && count_q != MAX) ? count_q + W'(1) : count_q;
    hit = count_d == MAX;
  end
  always_ff @(posedge clock) count_q <= reset ? '0 : count_d;
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: CPU/host arbiter for the single-port data memory
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              host_starved
);
  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic   hit;
  dm_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clock(clock),
    .reset(reset),
    .inc  (host_req && !host_gnt),
    .clr  (host_gnt || !host_req),
    .hit  (hit)
  );
  always_comb begin
    cpu_gnt      = !reset && cpu_req && (state_q == PRIO_CPU || !host_req);
    host_gnt     = !reset && host_req && (state_q == PRIO_HOST || !cpu_req);
    mem_address  = cpu_gnt ? cpu_addr : host_gnt ? host_addr : '0;
    mem_data     = cpu_gnt ? cpu_wdata : host_gnt ? host_wdata : '0;
    mem_wren     = (cpu_gnt && cpu_we) || (host_gnt && host_we);
    owner_d      = (cpu_gnt && !cpu_we) ? OWN_CPU : (host_gnt && !host_we) ? OWN_HOST : OWN_NONE;
    // PRIO_HOST lasts one cycle: either the host is served or it has gone away
    state_d      = (state_q == PRIO_CPU && hit) ? PRIO_HOST : PRIO_CPU;
    cpu_rvalid   = !reset && owner_q == OWN_CPU;
    host_rvalid  = !reset && owner_q == OWN_HOST;
    cpu_rdata    = mem_q;
    host_rdata   = mem_q;
    host_starved = !reset && state_q == PRIO_HOST;
  end
  always_ff @(posedge clock) begin
    state_q <= reset ? PRIO_CPU : state_d;
    owner_q <= reset ? OWN_NONE : owner_d;
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: randomized check of dm_arbiter against a behavioural model
module tb_dm_arbiter;
  localparam int LIMIT = 4;
  logic clock = 0, reset;
  logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic host_req, host_we, host_gnt, host_rvalid;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic [15:0] mem_address, mem_data, mem_q;
  logic mem_wren, host_starved;
  int n_cmp = 0, n_err = 0;

  dm_arbiter #(.ADDR_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .host_starved(host_starved)
  );

  always #5 clock = ~clock;

  // memory macro: registered read, write on the clock edge
  logic [15:0] mem [0:255];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257) ^ 16'h5a5a;
    forever begin
      @(posedge clock);
      mem_q <= mem[mem_address[7:0]];
      if (mem_wren) mem[mem_address[7:0]] = mem_data;
    end
  end

  // behavioural model state
  logic [15:0] ref_mem [0:255];
  int wait_m, pend_m;
  bit prio_m;
  logic [15:0] pend_data;
  bit l_r, l_cr, l_cw, l_hr, l_hw, e_cg, e_hg;
  logic [15:0] l_ca, l_cd, l_ha, l_hd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                       input bit hr, input bit hw, input logic [15:0] ha, input logic [15:0] hd);
    l_r = r; l_cr = cr; l_cw = cw; l_ca = ca; l_cd = cd;
    l_hr = hr; l_hw = hw; l_ha = ha; l_hd = hd;
    reset = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    #1;
    e_cg = 0;
    e_hg = 0;
    if (!r) begin
      if (cr && hr) begin
        if (prio_m) e_hg = 1;
        else e_cg = 1;
      end else begin
        e_cg = cr;
        e_hg = hr;
      end
    end
    chk("cpu_gnt", cpu_gnt, e_cg);
    chk("host_gnt", host_gnt, e_hg);
    chk("mem_address", mem_address, e_cg ? ca : e_hg ? ha : 16'h0);
    chk("mem_data", mem_data, e_cg ? cd : e_hg ? hd : 16'h0);
    chk("mem_wren", mem_wren, (e_cg && cw) || (e_hg && hw));
    chk("cpu_rvalid", cpu_rvalid, !r && pend_m == 1);
    chk("host_rvalid", host_rvalid, !r && pend_m == 2);
    chk("host_starved", host_starved, !r && prio_m);
    if (!r && pend_m == 1) chk("cpu_rdata", cpu_rdata, pend_data);
    if (!r && pend_m == 2) chk("host_rdata", host_rdata, pend_data);
  endtask

  task automatic advance();
    if (l_r) begin
      wait_m = 0; prio_m = 0; pend_m = 0;
    end else begin
      pend_m = 0;
      if (e_cg) begin
        if (l_cw) ref_mem[l_ca[7:0]] = l_cd;
        else begin pend_m = 1; pend_data = ref_mem[l_ca[7:0]]; end
      end
      if (e_hg) begin
        if (l_hw) ref_mem[l_ha[7:0]] = l_hd;
        else begin pend_m = 2; pend_data = ref_mem[l_ha[7:0]]; end
      end
      wait_m = (l_hr && !e_hg) ? ((wait_m < LIMIT) ? wait_m + 1 : LIMIT) : 0;
      prio_m = !prio_m && wait_m == LIMIT;
    end
    @(negedge clock);
  endtask

  task automatic idle();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    advance();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'(i * 257) ^ 16'h5a5a;
    wait_m = 0; pend_m = 0; prio_m = 0; pend_data = 0;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 16'h3, 16'h0, 1, 0, 16'h4, 16'h0);
      chk("lit_reset_cpu_gnt", cpu_gnt, 1'b0);
      advance();
    end
    // lone CPU load of 0x1234 at 0x0005
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0005, 16'h1234);
    advance();
    drive(0, 1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("lit_cpu_gnt", cpu_gnt, 1'b1);
    advance();
    idle_check_1234();
    // host store then CPU load of same address
    drive(0, 0, 0, 16'h0, 16'h0, 1, 1, 16'h0010, 16'hBEEF);
    advance();
    drive(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
    advance();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("lit_beef", cpu_rdata, 16'hBEEF);
    chk("lit_beef_valid", cpu_rvalid, 1'b1);
    advance();
    // both held high: host wins every fifth cycle
    for (int k = 0; k < 12; k++) begin
      drive(0, 1, 0, 16'(k), 16'h0, 1, 0, 16'(k + 32), 16'h0);
      chk("lit_starve_gnt", host_gnt, k == 4 || k == 9);
      chk("lit_starved", host_starved, k == 4 || k == 9);
      advance();
    end
    idle();
    // host withdraws after 2 denied cycles; wait count restarts
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 0, 16'h1, 16'h0, 1, 0, 16'h2, 16'h0);
      advance();
    end
    drive(0, 1, 0, 16'h1, 16'h0, 0, 0, 16'h2, 16'h0);
    chk("lit_withdraw_starved", host_starved, 1'b0);
    advance();
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 0, 16'h1, 16'h0, 1, 0, 16'h2, 16'h0);
      chk("lit_rewait_gnt", host_gnt, k == 4);
      advance();
    end
    idle();
    // reset right after a granted host load suppresses host_rvalid
    drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'h0007, 16'h0);
    advance();
    drive(1, 1, 1, 16'h9, 16'h1111, 1, 0, 16'h7, 16'h0);
    chk("lit_rst_host_rvalid", host_rvalid, 1'b0);
    chk("lit_rst_mem_wren", mem_wren, 1'b0);
    chk("lit_rst_mem_address", mem_address, 16'h0);
    advance();
    // alternating loads
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) drive(0, 1, 0, 16'(k), 16'h0, 0, 0, 16'h0, 16'h0);
      else drive(0, 0, 0, 16'h0, 16'h0, 1, 0, 16'(k), 16'h0);
      if (k > 0) chk("lit_alt_owner", host_rvalid, k % 2 == 0);
      advance();
    end
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            16'($urandom_range(0, 15)), 16'($urandom),
            $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
            16'($urandom_range(0, 15)), 16'($urandom));
      advance();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  task automatic idle_check_1234();
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    chk("lit_1234_valid", cpu_rvalid, 1'b1);
    chk("lit_1234_data", cpu_rdata, 16'h1234);
    chk("lit_1234_host_rvalid", host_rvalid, 1'b0);
    advance();
  endtask
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-requester arbiter for the single-port 16-bit data memory. It shares the memory between the CPU controller's load/store phase and a host/debug port used to preload or inspect memory while the CPU runs or is halted. The CPU has fixed priority, with a starvation guard for the host. It sits between both requesters and the memory macro, driving address, write data and write enable, and routes the registered read data back to the owner.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- STARVE_LIMIT, 4, consecutive denied host cycles before host gets priority (≥1)

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  16  CPU store data
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid (loads only)
- cpu_rdata  out  16  load data
- host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata: same as the cpu_* ports, for the host port
- mem_address  out  ADDR_W  to memory
- mem_data  out  16  to memory write data
- mem_wren  out  1  to memory write enable
- mem_q  in  16  memory read data, valid one cycle after address
- host_starved  out  1  high while the FSM is in PRIO_HOST

## Operation
- At most one access per cycle. The access is granted in the same cycle as the request is seen; gnt is combinational from req and the FSM state.
- FSM states: PRIO_CPU (reset state), PRIO_HOST.
  - PRIO_CPU: cpu_req wins. Host wins only if cpu_req = 0.
  - PRIO_HOST: host_req wins. CPU wins only if host_req = 0.
- Wait counter: host_wait (width clog2(STARVE_LIMIT+1)).
  - Increments each cycle host_req = 1 and host_gnt = 0.
  - Clears on host_gnt or when host_req = 0.
- Transitions:
  - PRIO_CPU → PRIO_HOST when host_wait reaches STARVE_LIMIT.
  - PRIO_HOST → PRIO_CPU on the cycle after host_gnt.
  - PRIO_HOST → PRIO_CPU if host_req drops.
- Memory signals:
  - Granted requester's addr/wdata are muxed to mem_address/mem_data.
  - mem_wren = we & gnt.
  - With no grant: mem_address = 0, mem_data = 0, mem_wren = 0.
- Read return:
  - Registered owner tag rd_owner ∈ {none, cpu, host} is set on a granted load.
  - Next cycle the tagged requester's rvalid = 1.
  - rdata = mem_q for both ports. Only rvalid qualifies the data.
- Writes produce no rvalid.
- A request withdrawn before grant is dropped silently. No request state is latched.

## Timing
- Reset values: cpu_gnt = host_gnt = 0, rvalid both 0, mem_wren = 0, mem_address = 0, host_starved = 0, state PRIO_CPU, host_wait = 0, rd_owner none. gnt outputs are forced low while reset = 1.
- Load latency: gnt in cycle N, rvalid and data in cycle N+1. Back-to-back loads return data every cycle.
- Write then read of the same address in consecutive cycles returns the new data.
- Simultaneous requests in PRIO_CPU: CPU granted, host_wait += 1.
- Simultaneous requests in PRIO_HOST: host granted, CPU waits exactly one cycle.
- Reset during an outstanding load: rvalid is suppressed in the next cycle.
- host_wait saturates at STARVE_LIMIT and never wraps.

## Structure
- The shared package holds:
  - the FSM state enum (PRIO_CPU, PRIO_HOST)
  - the owner enum (OWN_NONE, OWN_CPU, OWN_HOST)
  - the data width constant 16
- One natural sub-module, dm_starve_counter: a saturating wait counter with inc, clr and a hit output.
- The rest is flat: FSM, mux, owner register.

## Test plan
- Lone CPU load, addr 0x0005 holding 0x1234 → cpu_gnt same cycle, cpu_rvalid next cycle with cpu_rdata = 0x1234, host_rvalid = 0.
- Host store 0xBEEF to 0x0010, then CPU load of 0x0010 in the next cycle → CPU reads 0xBEEF.
- cpu_req and host_req held high continuously, STARVE_LIMIT = 4 → CPU granted 4 cycles, host granted in cycle 5 with host_starved = 1, CPU regranted in cycle 6, pattern repeats.
- Host request withdrawn after 2 denied cycles → host_wait returns to 0, state stays PRIO_CPU, no host_gnt.
- Reset asserted in the cycle after a granted host load → host_rvalid stays 0, all outputs at reset values.
- Alternating CPU/host loads every cycle → each rvalid lands only on the correct port with the correct data.
